// File: rtl/iir_filter_param.sv
// iir_filter_param: 1st/2nd order direct-form-I IIR filter.
// Full-precision accumulate, floor shift, saturation, sticky overflow.
module iir_filter_param #(
  parameter int WIDTH = 12,
  parameter int FRAC  = 11,
  parameter int ORDER = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic signed [WIDTH-1:0] DIN,
  input  logic                    VIN,
  input  logic signed [WIDTH-1:0] b0,
  input  logic signed [WIDTH-1:0] b1,
  input  logic signed [WIDTH-1:0] b2,
  input  logic signed [WIDTH-1:0] a1,
  input  logic signed [WIDTH-1:0] a2,
  input  logic                    COEF_LD,
  input  logic                    CLR,
  output logic signed [WIDTH-1:0] DOUT,
  output logic                    VOUT,
  output logic                    OVF
);
  localparam int PW  = 2 * WIDTH;
  localparam int ACC = 2 * WIDTH + 3;
  localparam logic signed [ACC-1:0] MAXV =
    $signed({{(ACC-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}});
  localparam logic signed [ACC-1:0] MINV = ~MAXV;

  logic signed [WIDTH-1:0] c_b0, c_b1, c_b2, c_a1, c_a2;
  logic signed [WIDTH-1:0] x1, x2, y1, y2;
  logic signed [PW-1:0]    p_b0, p_b1, p_b2, p_a1, p_a2;
  logic signed [ACC-1:0]   t_b2, t_a2;
  logic signed [ACC-1:0]   sum, shifted;
  logic signed [WIDTH-1:0] y_sat;
  logic                    ovr;

  function automatic logic signed [PW-1:0] sxw(
    input logic signed [WIDTH-1:0] v);
    return $signed({{WIDTH{v[WIDTH-1]}}, v});
  endfunction

  function automatic logic signed [ACC-1:0] sxa(
    input logic signed [PW-1:0] v);
    return $signed({{3{v[PW-1]}}, v});
  endfunction

  assign p_b0 = sxw(c_b0) * sxw(DIN);
  assign p_b1 = sxw(c_b1) * sxw(x1);
  assign p_b2 = sxw(c_b2) * sxw(x2);
  assign p_a1 = sxw(c_a1) * sxw(y1);
  assign p_a2 = sxw(c_a2) * sxw(y2);

  assign t_b2 = (ORDER == 2) ? sxa(p_b2) : '0;
  assign t_a2 = (ORDER == 2) ? sxa(p_a2) : '0;

  assign sum = sxa(p_b0) + sxa(p_b1) + t_b2
             - sxa(p_a1) - t_a2;
  assign shifted = sum >>> FRAC;

  // clamp the floored sum into the output range
  always_comb begin
    y_sat = shifted[WIDTH-1:0];
    ovr   = 1'b0;
    if (shifted > MAXV) begin
      y_sat = MAXV[WIDTH-1:0];
      ovr   = 1'b1;
    end else if (shifted < MINV) begin
      y_sat = MINV[WIDTH-1:0];
      ovr   = 1'b1;
    end
  end

  // coefficient shadow copy, refreshed only on COEF_LD
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      c_b0 <= '0;
      c_b1 <= '0;
      c_b2 <= '0;
      c_a1 <= '0;
      c_a2 <= '0;
    end else if (COEF_LD) begin
      c_b0 <= b0;
      c_b1 <= b1;
      c_a1 <= a1;
      c_b2 <= (ORDER == 2) ? b2 : '0;
      c_a2 <= (ORDER == 2) ? a2 : '0;
    end
  end

  // delay lines and sticky overflow; CLR overrides the shift
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      x1  <= '0;
      x2  <= '0;
      y1  <= '0;
      y2  <= '0;
      OVF <= 1'b0;
    end else begin
      if (VIN) begin
        x1 <= DIN;
        x2 <= x1;
        y1 <= y_sat;
        y2 <= y1;
        if (ovr) OVF <= 1'b1;
      end
      if (CLR) begin
        x1  <= '0;
        x2  <= '0;
        y1  <= '0;
        y2  <= '0;
        OVF <= 1'b0;
      end
    end
  end

  // registered output; DOUT holds between samples
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DOUT <= '0;
      VOUT <= 1'b0;
    end else begin
      VOUT <= VIN;
      if (VIN) DOUT <= y_sat;
    end
  end
endmodule

// File: doc/iir_filter_param.md
IIR_FILTER_PARAM -- requirements
Module: iir_filter_param

Interface
REQ-001 Parameter WIDTH, default 12, SHALL set the signed two's-complement width of DIN, DOUT and every coefficient port.
REQ-002 Parameter FRAC, default 11, SHALL set the number of fractional bits in every coefficient (legal range 1..WIDTH-1).
REQ-003 Parameter ORDER, default 1, SHALL select first-order (1) or second-order (2) operation; any other value is illegal.
REQ-004 CLK  input  1  single clock; every register SHALL update on its rising edge.
REQ-005 RST  input  1  reset; SHALL be asynchronous and active-high.
REQ-006 DIN  input  WIDTH  input sample x[n], signed.
REQ-007 VIN  input  1  sample-valid strobe; DIN is consumed on every cycle VIN=1.
REQ-008 b0, b1, b2, a1, a2  input  WIDTH each  signed coefficients, sampled only on COEF_LD.
REQ-009 COEF_LD  input  1  coefficient-load strobe.
REQ-010 CLR  input  1  synchronous clear of filter history and OVF.
REQ-011 DOUT  output  WIDTH  filtered sample y[n], signed, registered.
REQ-012 VOUT  output  1  output-valid strobe, registered.
REQ-013 OVF  output  1  sticky saturation flag, registered.

Function
REQ-014 Transfer: y[n] = b0*x[n] + b1*x[n-1] + b2*x[n-2] - a1*y[n-1] - a2*y[n-2], direct form I, using the internally held coefficient copy.
REQ-015 For ORDER=1, the b2 and a2 terms SHALL contribute zero, and the ports SHALL be ignored.
REQ-016 Each product SHALL be the full 2*WIDTH-bit signed product.
REQ-017 The sum SHALL be accumulated in 2*WIDTH+3 bits, with no intermediate truncation.
REQ-018 The sum SHALL be arithmetically shifted right by FRAC bits (floor, i.e. round toward minus infinity).
REQ-019 The shifted sum SHALL be saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-020 The saturated value SHALL be both DOUT and the value stored as y[n-1] history.
REQ-021 The delay lines x[n-1], x[n-2], y[n-1], y[n-2] SHALL shift only on cycles with VIN=1; on VIN=0 all state SHALL hold.
REQ-022 Latency: VOUT SHALL be 1 exactly one cycle after each VIN=1 cycle, with DOUT valid in that same cycle.
REQ-023 VOUT SHALL be 0 otherwise, and DOUT SHALL hold its last value while VOUT=0.
REQ-024 Back-to-back VIN=1 SHALL be accepted every cycle, giving throughput of 1 sample/cycle with no stall or backpressure.
REQ-025 COEF_LD=1 SHALL copy all coefficient ports into the internal registers at that edge.
REQ-026 A sample with VIN=1 in the same cycle as COEF_LD SHALL use the old coefficients; the new coefficients SHALL apply from the next sample.
REQ-027 CLR=1 SHALL zero all four history registers and OVF at that edge, and SHALL not alter coefficients, DOUT or VOUT.
REQ-028 A sample with VIN=1 in the same cycle as CLR SHALL be computed with pre-clear history.
REQ-029 The history registers SHALL then be zeroed, so the sample's own terms are not retained.
REQ-030 VOUT SHALL still pulse for the sample accepted with CLR.
REQ-031 OVF SHALL set on any sample whose shifted sum lies outside the WIDTH range.
REQ-032 OVF SHALL stay set until CLR or RST; when CLR and overflow coincide, CLR SHALL win.

Reset
REQ-033 RST=1 SHALL immediately and asynchronously clear DOUT, VOUT, OVF, all history registers and all internal coefficients to 0.
REQ-034 A sample in progress when RST asserts SHALL be discarded, and no VOUT pulse SHALL follow.
REQ-035 After RST deasserts, the first VIN=1 sample SHALL be processed with zero history.
REQ-036 Until COEF_LD is asserted after reset, DOUT SHALL be 0 for every sample.

Verification (WIDTH=12, FRAC=11, ORDER=1 unless stated)
REQ-037 Single-pole impulse: load b0=1024, b1=0, a1=-1024, then apply DIN=2000 then zeros with VIN=1 each cycle -> DOUT = 1000, 500, 250, 125, 62, 31, each one cycle after its VIN, with VOUT=1 each cycle and OVF=0.
REQ-038 Positive saturation: load b0=b1=2047, a1=0, then apply DIN=2047 held for two samples -> DOUT=2046 then 2047, with OVF=1 from the second output onward.
REQ-039 Negative saturation and floor: with b0=b1=2047, DIN=-2048 held gives DOUT=-2047 then -2048.
REQ-040 Floor check: with b0=1024, DIN=-1 gives DOUT=-1.
REQ-041 Gapped VIN and coefficient coincidence: repeat REQ-037 with VIN=0 for 3 cycles between samples -> identical DOUT sequence, DOUT holds and VOUT=0 during gaps.
REQ-042 Coefficient coincidence: assert COEF_LD with b0=2047 on the same cycle as a sample -> that sample uses b0=1024 and the next uses 2047.
REQ-043 Second order: ORDER=2, b0=2047, a2=1024, others 0, DIN=2000 then zeros -> DOUT = 1999, 0, -1000, 0, 500, 0, -250.
REQ-044 CLR and RST mid-stream: CLR mid-sequence of REQ-037 restarts decay from zero history and clears OVF.
REQ-045 RST pulse of half a cycle between clock edges -> DOUT, VOUT and OVF go to 0 before the next edge, and post-reset samples give DOUT=0 until COEF_LD.
